// File: rtl/reg_scoreboard_pkg.sv
// rtl/reg_scoreboard_pkg.sv - shared scoreboard sizes, stage indices and pipe entry type
package reg_scoreboard_pkg;

   localparam int REG_W     = 3;
   localparam int NREG      = 2 ** REG_W;
   localparam int DEPTH     = 3;
   localparam int CNT_W     = 2;
   // Register file forwards WB writes to same-cycle reads, so WB entries do not stall.
   localparam bit WB_BYPASS = 1'b1;

   localparam int ST_EX  = 0;
   localparam int ST_MEM = 1;
   localparam int ST_WB  = 2;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] dst;
   } sb_entry_t;

endpackage

// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - issue/flush/hazard/retire signals between pipeline control and scoreboard
interface reg_scoreboard_if;
   import reg_scoreboard_pkg::*;

   logic             freeze;
   logic             issue_valid;
   logic             issue_regwrite;
   logic [REG_W-1:0] issue_dst;
   logic             flush_ex;
   logic [REG_W-1:0] rs_id;
   logic [REG_W-1:0] rt_id;
   logic             rs_active;
   logic             rt_active;
   logic [NREG-1:0]  busy;
   logic             stall_rs;
   logic             stall_rt;
   logic             stall;
   logic             retire_valid;
   logic [REG_W-1:0] retire_dst;

   modport master (
      output freeze, issue_valid, issue_regwrite, issue_dst, flush_ex,
             rs_id, rt_id, rs_active, rt_active,
      input  busy, stall_rs, stall_rt, stall, retire_valid, retire_dst
   );

   modport slave (
      input  freeze, issue_valid, issue_regwrite, issue_dst, flush_ex,
             rs_id, rt_id, rs_active, rt_active,
      output busy, stall_rs, stall_rt, stall, retire_valid, retire_dst
   );

endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// rtl/reg_scoreboard_sb_counter.sv - per-register pending-writer counter
module sb_counter
   import reg_scoreboard_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic freeze,
   input  logic inc,
   input  logic dec_retire,
   input  logic dec_flush,
   output logic nonzero
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // All hits of one cycle net out in a single update.
   always_comb begin
      cnt_d = cnt_q;
      if (!freeze) begin
         cnt_d = cnt_q + CNT_W'(inc) - CNT_W'(dec_retire) - CNT_W'(dec_flush);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign nonzero = (cnt_q != '0);

endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - tracks register writers through EX/MEM/WB and raises ID read stalls
module reg_scoreboard
   import reg_scoreboard_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   reg_scoreboard_if.slave sb
);

   sb_entry_t [DEPTH-1:0] pipe_q;
   sb_entry_t [DEPTH-1:0] pipe_d;
   logic [NREG-1:0]       busy_w;
   logic                  issue_we;
   logic                  rs_hit;
   logic                  rt_hit;

   assign issue_we = sb.issue_valid & sb.issue_regwrite;

   always_comb begin
      pipe_d = pipe_q;
      if (!sb.freeze) begin
         pipe_d[ST_WB]  = pipe_q[ST_MEM];
         pipe_d[ST_MEM] = sb.flush_ex ? '0 : pipe_q[ST_EX];
         pipe_d[ST_EX]  = '{valid: issue_we, dst: sb.issue_dst};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_q <= '0;
      end else begin
         pipe_q <= pipe_d;
      end
   end

   for (genvar r = 0; r < NREG; r++) begin : g_cnt
      sb_counter u_cnt (
         .clk        (clk),
         .rst_n      (rst_n),
         .freeze     (sb.freeze),
         .inc        (issue_we && (sb.issue_dst == REG_W'(r))),
         .dec_retire (pipe_q[ST_WB].valid && (pipe_q[ST_WB].dst == REG_W'(r))),
         .dec_flush  (sb.flush_ex && pipe_q[ST_EX].valid && (pipe_q[ST_EX].dst == REG_W'(r))),
         .nonzero    (busy_w[r])
      );
   end

   // With WB bypass only EX and MEM writers are hazards; otherwise any pending writer is.
   if (WB_BYPASS) begin : g_byp
      assign rs_hit = (pipe_q[ST_EX].valid  && (pipe_q[ST_EX].dst  == sb.rs_id)) ||
                      (pipe_q[ST_MEM].valid && (pipe_q[ST_MEM].dst == sb.rs_id));
      assign rt_hit = (pipe_q[ST_EX].valid  && (pipe_q[ST_EX].dst  == sb.rt_id)) ||
                      (pipe_q[ST_MEM].valid && (pipe_q[ST_MEM].dst == sb.rt_id));
   end else begin : g_nobyp
      assign rs_hit = busy_w[sb.rs_id];
      assign rt_hit = busy_w[sb.rt_id];
   end

   assign sb.busy         = busy_w;
   assign sb.stall_rs     = sb.rs_active & rs_hit;
   assign sb.stall_rt     = sb.rt_active & rt_hit;
   assign sb.stall        = sb.stall_rs | sb.stall_rt;
   assign sb.retire_valid = pipe_q[ST_WB].valid & ~sb.freeze;
   assign sb.retire_dst   = pipe_q[ST_WB].dst;

endmodule
